// File: rtl/rv_fetch.sv
// Instruction fetch stage: owns the fetch PC, drives a single-outstanding instruction bus, and buffers words in a prefetch queue.
// Define FETCH_PREFETCH_EN for a two-entry queue (overlapped fetch); the default build uses a single entry.
module rv_fetch #(
  parameter logic [31:0] RESET_ADDR = 32'h0000_0000
) (
  input  logic        i_clk,
  input  logic        i_reset_n,
  input  logic        i_stall,
  input  logic        i_pc_sel,
  input  logic [31:0] i_pc_target,
  output logic        o_bus_req,
  output logic [31:0] o_bus_addr,
  input  logic        i_bus_ack,
  input  logic [31:0] i_bus_data,
  output logic        o_valid,
  output logic [31:0] o_instr,
  output logic [31:0] o_pc
);

`ifdef FETCH_PREFETCH_EN
  localparam int unsigned DEPTH = 2;
`else
  localparam int unsigned DEPTH = 1;
`endif
  localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CNT_W = $clog2(DEPTH + 1);
  localparam logic [CNT_W-1:0] DEPTH_C  = CNT_W'(DEPTH);
  localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(DEPTH - 1);

  typedef enum logic [1:0] {IDLE, REQ, DISCARD} state_e;

  state_e           state_q, state_d;
  logic [31:0]      pc_q, pc_d;
  logic [31:0]      tgt_q, tgt_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [31:0]      q_pc_q    [DEPTH];
  logic [31:0]      q_instr_q [DEPTH];

  logic             push, pop, room;
  logic [CNT_W-1:0] count_nx;
  logic [31:0]      target;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_LAST) ? '0 : p + PTR_W'(1);
  endfunction

  assign target = i_pc_target & 32'hFFFF_FFFC;
  assign pop    = (count_q != '0) & !i_stall & !i_pc_sel;
  assign push   = i_bus_ack & (state_q == REQ) & !i_pc_sel;

  // Occupancy after this edge, ignoring redirect; gates new requests so every ack has a free slot.
  always_comb begin
    count_nx = count_q;
    unique case ({push, pop})
      2'b10:   count_nx = count_q + CNT_W'(1);
      2'b01:   count_nx = count_q - CNT_W'(1);
      default: count_nx = count_q;
    endcase
  end

  assign room = (count_nx < DEPTH_C);

  always_comb begin
    count_d  = count_nx;
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    if (i_pc_sel) begin
      count_d  = '0;
      rd_ptr_d = '0;
      wr_ptr_d = '0;
    end else begin
      if (push) wr_ptr_d = ptr_inc(wr_ptr_q);
      if (pop)  rd_ptr_d = ptr_inc(rd_ptr_q);
    end
  end

  always_ff @(posedge i_clk) begin
    if (!i_reset_n) begin
      count_q   <= '0;
      rd_ptr_q  <= '0;
      wr_ptr_q  <= '0;
      q_pc_q    <= '{default: '0};
      q_instr_q <= '{default: '0};
    end else begin
      count_q  <= count_d;
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      if (push) begin
        q_pc_q[wr_ptr_q]    <= pc_q;
        q_instr_q[wr_ptr_q] <= i_bus_data;
      end
    end
  end

  always_ff @(posedge i_clk) begin
    if (!i_reset_n) begin
      state_q <= IDLE;
      pc_q    <= RESET_ADDR;
      tgt_q   <= RESET_ADDR;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      tgt_q   <= tgt_d;
    end
  end

  // In DISCARD the bus keeps the stale address until its ack; the redirect target waits in tgt_q.
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    tgt_d   = tgt_q;
    unique case (state_q)
      IDLE: begin
        if (i_pc_sel) begin
          state_d = REQ;
          pc_d    = target;
        end else if (room) begin
          state_d = REQ;
        end
      end
      REQ: begin
        if (i_bus_ack) begin
          if (i_pc_sel) begin
            pc_d = target;
          end else begin
            pc_d = pc_q + 32'd4;
            if (!room) state_d = IDLE;
          end
        end else if (i_pc_sel) begin
          state_d = DISCARD;
          tgt_d   = target;
        end
      end
      DISCARD: begin
        if (i_bus_ack) begin
          state_d = REQ;
          pc_d    = i_pc_sel ? target : tgt_q;
        end else if (i_pc_sel) begin
          tgt_d = target;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    o_bus_req  = (state_q != IDLE);
    o_bus_addr = pc_q;
    o_valid    = (count_q != '0);
    o_instr    = q_instr_q[rd_ptr_q];
    o_pc       = q_pc_q[rd_ptr_q];
  end

endmodule

// File: tb/tb_rv_fetch.sv
// Scoreboard bench for rv_fetch: transaction-level reference model plus a negedge monitor.
module tb_rv_fetch;
  localparam logic [31:0] RST = 32'h0000_0100;
`ifdef FETCH_PREFETCH_EN
  localparam int DEPTH = 2;
`else
  localparam int DEPTH = 1;
`endif

  logic        clk = 1'b0;
  logic        i_reset_n, i_stall, i_pc_sel, i_bus_ack;
  logic [31:0] i_pc_target, i_bus_data;
  logic        o_bus_req, o_valid;
  logic [31:0] o_bus_addr, o_instr, o_pc;

  always #5 clk = ~clk;

  rv_fetch #(.RESET_ADDR(RST)) dut (
    .i_clk      (clk),
    .i_reset_n  (i_reset_n),
    .i_stall    (i_stall),
    .i_pc_sel   (i_pc_sel),
    .i_pc_target(i_pc_target),
    .o_bus_req  (o_bus_req),
    .o_bus_addr (o_bus_addr),
    .i_bus_ack  (i_bus_ack),
    .i_bus_data (i_bus_data),
    .o_valid    (o_valid),
    .o_instr    (o_instr),
    .o_pc       (o_pc)
  );

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } ent_t;

  ent_t        mq[$];   // reference model's view of the prefetch queue
  ent_t        sb[$];   // expected decode hand-offs, consumed by the monitor
  int          checks = 0;
  int          errors = 0;
  bit          started = 0;
  logic [31:0] m_pc, m_tgt;
  bit          m_busy, m_stale, m_fresh;

  // Memory contents as a function of address, so stale words are distinguishable.
  function automatic logic [31:0] mem(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'hC0DE_0000;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h t=%0t", nm, act, exp, $time);
    end
  endtask

  task automatic model(input bit rst_n, input bit stall, input bit sel,
                       input logic [31:0] tgt, input bit ack);
    bit   acked, popq;
    ent_t e;
    if (!rst_n) begin
      m_pc = RST; m_tgt = RST; m_busy = 0; m_stale = 0; m_fresh = 1;
      mq.delete(); sb.delete();
      return;
    end
    acked = m_busy && ack;
    popq  = (mq.size() != 0) && !stall && !sel;
    if (sel) begin
      mq.delete(); sb.delete();
      if (acked || !m_busy) begin
        m_pc = tgt & ~32'd3; m_busy = 1; m_stale = 0;
      end else begin
        m_tgt = tgt & ~32'd3; m_stale = 1;
      end
    end else begin
      if (popq) void'(mq.pop_front());
      if (acked && m_stale) begin
        m_pc = m_tgt; m_stale = 0;
      end else begin
        if (acked) begin
          e.pc = m_pc; e.instr = mem(m_pc);
          mq.push_back(e); sb.push_back(e);
          m_pc = m_pc + 32'd4; m_fresh = 0;
        end
        if (acked || !m_busy) m_busy = (mq.size() < DEPTH);
      end
    end
  endtask

  task automatic step(input bit rst_n, input bit stall, input bit sel,
                      input logic [31:0] tgt, input bit ack);
    i_reset_n   = rst_n;
    i_stall     = stall;
    i_pc_sel    = sel;
    i_pc_target = tgt;
    i_bus_ack   = ack;
    i_bus_data  = ack ? mem(o_bus_addr) : $urandom;
    @(posedge clk);
    model(rst_n, stall, sel, tgt, ack);
    #1;
    if (!rst_n) started = 1;
  endtask

  always @(negedge clk) begin
    ent_t e;
    if (started) begin
      chk("bus_req", 32'(o_bus_req), 32'(m_busy));
      chk("bus_addr", o_bus_addr, m_pc);
      chk("valid", 32'(o_valid), 32'(mq.size() != 0));
      if (m_fresh) begin
        chk("reset_pc", o_pc, 32'h0);
        chk("reset_instr", o_instr, 32'h0);
      end
      if (o_valid === 1'b1 && !i_stall && !i_pc_sel && i_reset_n) begin
        if (sb.size() == 0) begin
          chk("pop_unexpected", 32'(o_valid), 32'h0);
        end else begin
          e = sb.pop_front();
          chk("head_pc", o_pc, e.pc);
          chk("head_instr", o_instr, e.instr);
        end
      end
    end
  end

  initial begin
    bit          a, s, r;
    logic [31:0] t;
    repeat (3) step(0, 0, 0, 32'h0, 0);
    // zero-wait bus, no stall
    repeat (12) step(1, 0, 0, 32'h0, 1);
    // stall until the queue fills, then release
    repeat (6) step(1, 1, 0, 32'h0, 1);
    repeat (4) step(1, 0, 0, 32'h0, 1);
    // redirect to 0x203 while a request is pending with slow ack
    step(0, 0, 0, 32'h0, 0);
    repeat (2) step(1, 0, 0, 32'h0, 1);
    step(1, 0, 0, 32'h0, 0);
    step(1, 0, 1, 32'h203, 0);
    step(1, 0, 0, 32'h0, 0);
    step(1, 0, 0, 32'h0, 1);
    repeat (3) step(1, 0, 0, 32'h0, 0);
    repeat (4) step(1, 0, 0, 32'h0, 1);
    // redirect coinciding with an ack
    step(1, 0, 1, 32'h341, 1);
    repeat (4) step(1, 0, 0, 32'h0, 1);
    // randomized traffic
    repeat (3000) begin
      a = o_bus_req ? ($urandom_range(0, 1) == 1) : ($urandom_range(0, 9) == 0);
      s = ($urandom_range(0, 2) == 0);
      r = ($urandom_range(0, 19) == 0);
      t = $urandom;
      step(($urandom_range(0, 499) != 0), s, r, t, a);
    end
    // reset while a request is outstanding
    for (int k = 0; k < 20 && !o_bus_req; k++) step(1, 0, 0, 32'h0, 0);
    chk("req_before_reset", 32'(o_bus_req), 32'h1);
    step(0, 0, 0, 32'h0, 0);
    repeat (3) step(1, 0, 0, 32'h0, 1);
    @(negedge clk);
    #1;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/rv_fetch.md
# rv_fetch

Instruction fetch stage of the pipelined core. It owns the fetch PC and drives a single-outstanding instruction bus, buffering returned words in a small prefetch queue. It presents {PC, instruction} to decode. It consumes the control unit's fetch-stall and PC-redirect signals, and its valid output is the fetch-acknowledge the control unit uses to stall decode and flush execute.

## Interface

- RESET_ADDR, 32'h0000_0000, first fetch address after reset; bits [1:0] must be 0.
- i_clk  in  1  clock; all logic samples on the rising edge.
- i_reset_n  in  1  reset, synchronous, active-low.
- i_stall  in  1  fetch stall from control; blocks the decode pop.
- i_pc_sel  in  1  redirect request from execute (taken branch or jump).
- i_pc_target  in  32  redirect target; bits [1:0] ignored and forced 0.
- o_bus_req  out  1  instruction bus request.
- o_bus_addr  out  32  word address of the request.
- i_bus_ack  in  1  bus acknowledge; qualifies i_bus_data in the same cycle.
- i_bus_data  in  32  returned instruction word.
- o_valid  out  1  head entry valid; drives the control unit's i_fetch_bus_ack.
- o_instr  out  32  head instruction.
- o_pc  out  32  head PC.

## Operation

- Queue: DEPTH entries of {pc, instr}, with count plus read and write pointers (DEPTH is set under Configuration).
- Pop: o_valid & !i_stall & !i_pc_sel.
- Push: i_bus_ack & (state==REQ) & !i_pc_sel.
- count_next = count + push - pop. Pointers wrap modulo DEPTH. Simultaneous push and pop is legal.
- Redirect (i_pc_sel): clears the queue (count=0, pointers=0) and loads fetch PC with {i_pc_target[31:2],2'b00}. Redirect has priority over push and pop in the same cycle.
- Bus rules:
  - o_bus_req = (state != IDLE).
  - o_bus_addr is held stable while o_bus_req=1 and i_bus_ack=0.
  - At most one request is outstanding.
  - An ack is only honoured while o_bus_req=1.
- Reservation: a new request is issued only if count_next < DEPTH. Every ack therefore finds a free entry, so overflow cannot occur.
- FSM states:
  - IDLE → REQ when count_next < DEPTH, or on i_pc_sel.
  - REQ, ack, no pc_sel: PC += 4. Stay in REQ if count_next < DEPTH, else go to IDLE.
  - REQ, ack with pc_sel: data dropped; stay in REQ with addr = target.
  - REQ, pc_sel without ack: go to DISCARD; the bus address stays on the stale value.
  - DISCARD, ack: data dropped; go to REQ with addr = the latched target.
  - DISCARD, another pc_sel: the latched target is replaced; stay in DISCARD.
- Reset values: state IDLE, o_bus_req 0, o_bus_addr RESET_ADDR, fetch PC RESET_ADDR, o_valid 0, o_instr 0, o_pc 0, count 0, pointers 0.
- Reset asserted mid-transaction drops the request immediately, and any queued data is lost.

## Timing

- Reset released at edge N: o_bus_req=1 with o_bus_addr=RESET_ADDR after edge N+1.
- Ack at edge M: o_valid=1 with the new word after edge M (registered, one-cycle latency).
- A same-cycle ack is accepted; there is no minimum wait.
- Zero-wait bus with a large queue: one instruction per cycle.
- Redirect at edge R, no request pending: request to the target after edge R; first valid instruction after the following ack.
- Redirect while a request is pending: the target request starts the cycle after the stale ack.
- o_valid drops to 0 after the redirect edge.

## Configuration

- FETCH_PREFETCH_EN defined: DEPTH=2. The next request overlaps with an unconsumed head entry, giving sustained 1 instr/cycle on a zero-wait bus.
- FETCH_PREFETCH_EN undefined: DEPTH=1. A request is issued only when the queue will be empty after this cycle, either empty or being popped. Peak rate is one instruction every 2 cycles with a zero-wait bus. The FSM and the redirect rules are unchanged.

## Test plan

- Reset release with RESET_ADDR=0x100, bus acks in the same cycle → addresses 0x100, 0x104, 0x108 on consecutive cycles. o_valid first high one cycle after the first ack, with o_pc=0x100.
- Hold i_stall=1 with PREFETCH_EN → exactly two words buffered, then o_bus_req=0. Releasing the stall pops 0x100 and re-issues the request the same cycle.
- Redirect to 0x203 while a request to 0x108 is pending with a 3-cycle ack → 0x108 data never appears on o_instr. The next request is 0x200 and o_valid is 0 until its ack.
- Redirect in the same cycle as an ack → acked word dropped, next o_bus_addr=target, queue empty.
- Without PREFETCH_EN, zero-wait bus, no stall → o_valid toggles 1,0,1,0; the PC sequence is contiguous by 4.
- Reset asserted while o_bus_req=1 → after the edge, o_bus_req=0, o_valid=0, o_bus_addr=RESET_ADDR.
